// File: rtl/jk_ctrl_pkg.sv
// Shared opcodes and FSM state encoding for the JK bank controller.
package jk_ctrl_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOP    = 3'd0;
  localparam logic [OP_W-1:0] OP_LOAD   = 3'd1;
  localparam logic [OP_W-1:0] OP_CLEAR  = 3'd2;
  localparam logic [OP_W-1:0] OP_SET    = 3'd3;
  localparam logic [OP_W-1:0] OP_TOGGLE = 3'd4;
  localparam logic [OP_W-1:0] OP_CNT_UP = 3'd5;
  localparam logic [OP_W-1:0] OP_CNT_DN = 3'd6;
  localparam logic [OP_W-1:0] OP_SHL    = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // True for opcodes whose step count comes from cmd_count.
  function automatic logic is_multi_step(input logic [OP_W-1:0] op);
    return (op == OP_CNT_UP) || (op == OP_CNT_DN) || (op == OP_SHL);
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop: 00 hold, 01 clear, 10 set, 11 toggle.
module jk_cell (
  input  logic clock,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  // JK state update with synchronous clear on reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_bank_ctrl.sv
// Command sequencer driving per-bit J/K for a bank of JK cells.
module jk_bank_ctrl
  import jk_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OP_W-1:0]  cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  state_t             state;
  logic [OP_W-1:0]    op_r;
  logic [WIDTH-1:0]   data_r;
  logic [CNT_W-1:0]   remaining;
  logic [CNT_W-1:0]   steps_c;
  logic [WIDTH-1:0]   j_c;
  logic [WIDTH-1:0]   k_c;
  logic [WIDTH-1:0]   t_up_c;
  logic [WIDTH-1:0]   t_dn_c;
  logic [WIDTH-1:0]   shl_c;

  // Number of RUN cycles an incoming command needs.
  always_comb begin
    steps_c = '0;
    if (is_multi_step(cmd_op)) begin
      steps_c = cmd_count;
    end else if (cmd_op != OP_NOP) begin
      steps_c = CNT_W'(1);
    end
  end

  // Controller FSM with registered handshake/status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      op_r      <= '0;
      data_r    <= '0;
      remaining <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_r      <= cmd_op;
            data_r    <= cmd_data;
            remaining <= steps_c;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (steps_c == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (remaining != '0) begin
            remaining <= remaining - CNT_W'(1);
          end
          if (remaining <= CNT_W'(1)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
        default: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

  // Ripple toggle enables for up/down counting and the shifted next value.
  always_comb begin
    t_up_c    = '0;
    t_dn_c    = '0;
    t_up_c[0] = 1'b1;
    t_dn_c[0] = 1'b1;
    for (int i = 1; i < int'(WIDTH); i++) begin
      t_up_c[i] = t_up_c[i-1] & q[i-1];
      t_dn_c[i] = t_dn_c[i-1] & ~q[i-1];
    end
    shl_c = {q[WIDTH-2:0], data_r[0]};
  end

  // Per-bit J/K drive; hold everywhere except RUN.
  always_comb begin
    j_c = '0;
    k_c = '0;
    if (state == S_RUN) begin
      case (op_r)
        OP_LOAD:   begin j_c = data_r;    k_c = ~data_r; end
        OP_CLEAR:  begin j_c = '0;        k_c = '1;      end
        OP_SET:    begin j_c = '1;        k_c = '0;      end
        OP_TOGGLE: begin j_c = data_r;    k_c = data_r;  end
        OP_CNT_UP: begin j_c = t_up_c;    k_c = t_up_c;  end
        OP_CNT_DN: begin j_c = t_dn_c;    k_c = t_dn_c;  end
        OP_SHL:    begin j_c = shl_c;     k_c = ~shl_c;  end
        default:   begin j_c = '0;        k_c = '0;      end
      endcase
    end
  end

  // Bank of JK storage cells.
  for (genvar g = 0; g < int'(WIDTH); g++) begin : g_cell
    jk_cell u_cell (
      .clock (clock),
      .reset (reset),
      .j     (j_c[g]),
      .k     (k_c[g]),
      .q     (q[g])
    );
  end

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Self-checking bench for jk_bank_ctrl against an arithmetic reference model.
module tb_jk_bank_ctrl;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 8;
  localparam int          MASK  = (1 << WIDTH) - 1;

  logic             clock;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;
  int model_q = 0;

  jk_bank_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_count (cmd_count),
    .q         (q),
    .busy      (busy),
    .done      (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference: effect of one RUN step on the bank, in plain arithmetic.
  function automatic int ref_step(input int op, input int data, input int cur);
    case (op)
      1: return data & MASK;
      2: return 0;
      3: return MASK;
      4: return (cur ^ data) & MASK;
      5: return (cur + 1) & MASK;
      6: return (cur + MASK) & MASK;
      7: return ((cur << 1) | (data & 1)) & MASK;
      default: return cur;
    endcase
  endfunction

  function automatic int ref_steps(input int op, input int cnt);
    if (op == 0) return 0;
    if (op <= 4) return 1;
    return cnt;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Issue one command and check the full accept/RUN/DONE/IDLE timeline.
  task automatic run_cmd(input int op, input int data, input int cnt, input bit hold_junk);
    int n;
    int waited;
    waited = 0;
    while (cmd_ready !== 1'b1 && waited < 100) begin
      step();
      waited++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_ready: got %b expected 1", cmd_ready);
    end
    n = ref_steps(op, cnt);
    cmd_valid = 1'b1;
    cmd_op    = 3'(op);
    cmd_data  = WIDTH'(data);
    cmd_count = CNT_W'(cnt);
    step();
    if (hold_junk) begin
      cmd_op    = 3'd3;
      cmd_data  = WIDTH'($urandom);
      cmd_count = CNT_W'($urandom_range(1, 9));
    end else begin
      cmd_valid = 1'b0;
      cmd_op    = 3'($urandom);
      cmd_data  = WIDTH'($urandom);
      cmd_count = CNT_W'($urandom);
    end
    for (int s = 1; s <= n; s++) begin
      if (cmd_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL run_status op=%0d step=%0d: got ready=%b busy=%b done=%b expected 0 1 0",
                 op, s, cmd_ready, busy, done);
      end
      checks++;
      step();
      model_q = ref_step(op, data, model_q);
      chk($sformatf("run_q op=%0d step=%0d", op, s), int'(q), model_q);
    end
    if (cmd_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b1) begin
      errors++;
      $display("FAIL done_status op=%0d: got ready=%b busy=%b done=%b expected 0 1 1",
               op, cmd_ready, busy, done);
    end
    checks++;
    chk($sformatf("done_q op=%0d", op), int'(q), model_q);
    step();
    cmd_valid = 1'b0;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_status op=%0d: got ready=%b busy=%b done=%b expected 1 0 0",
               op, cmd_ready, busy, done);
    end
    checks++;
    chk($sformatf("idle_q op=%0d", op), int'(q), model_q);
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_data  = '0;
    cmd_count = '0;
    step();
    step();
    chk("reset_q", int'(q), 0);
    chk("reset_ready", int'(cmd_ready), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    reset = 1'b0;
    model_q = 0;
    repeat (5) step();
    chk("idle_hold_q", int'(q), 0);
    chk("idle_hold_ready", int'(cmd_ready), 1);
  endtask

  task automatic test_single_step();
    run_cmd(1, 4'b1010, 0, 1'b0);
    chk("load_value", int'(q), 4'b1010);
    run_cmd(4, 4'b0110, 0, 1'b0);
    chk("toggle_value", int'(q), 4'b1100);
    run_cmd(3, 0, 0, 1'b0);
    chk("set_value", int'(q), 4'b1111);
    run_cmd(2, 0, 0, 1'b0);
    chk("clear_value", int'(q), 4'b0000);
  endtask

  task automatic test_counting();
    run_cmd(1, 4'b1101, 0, 1'b0);
    run_cmd(5, 0, 5, 1'b0);
    chk("cnt_up_wrap", int'(q), 4'b0010);
    run_cmd(6, 0, 3, 1'b0);
    chk("cnt_dn_wrap", int'(q), 4'b1111);
  endtask

  task automatic test_shift();
    run_cmd(2, 0, 0, 1'b0);
    run_cmd(7, 4'b0001, 3, 1'b0);
    chk("shl_value", int'(q), 4'b0111);
  endtask

  task automatic test_zero_step();
    run_cmd(5, 0, 0, 1'b0);
    chk("cnt0_q_unchanged", int'(q), 4'b0111);
    run_cmd(0, 4'b1111, 7, 1'b0);
    chk("nop_q_unchanged", int'(q), 4'b0111);
  endtask

  task automatic test_ignore_busy();
    run_cmd(5, 0, 4, 1'b1);
    chk("busy_ignored_q", int'(q), 4'b1011);
    run_cmd(3, 0, 0, 1'b0);
    chk("accepted_after_idle", int'(q), 4'b1111);
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    run_cmd(2, 0, 0, 1'b0);
    cmd_valid = 1'b1;
    cmd_op    = 3'd5;
    cmd_data  = '0;
    cmd_count = CNT_W'(10);
    step();
    cmd_valid = 1'b0;
    saw_done = 1'b0;
    for (int s = 1; s <= 3; s++) begin
      step();
      model_q = (model_q + 1) & MASK;
      if (done === 1'b1) saw_done = 1'b1;
    end
    chk("mid_q_before_reset", int'(q), 3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_q = 0;
    chk("mid_reset_q", int'(q), 0);
    chk("mid_reset_ready", int'(cmd_ready), 1);
    chk("mid_reset_busy", int'(busy), 0);
    for (int s = 0; s < 15; s++) begin
      if (done === 1'b1) saw_done = 1'b1;
      step();
    end
    chk("mid_reset_no_done", int'(saw_done), 0);
    chk("mid_reset_q_hold", int'(q), 0);
  endtask

  task automatic test_random();
    int op;
    int data;
    int cnt;
    for (int r = 0; r < 40; r++) begin
      op   = int'($urandom_range(0, 7));
      data = int'($urandom_range(0, MASK));
      cnt  = int'($urandom_range(0, 20));
      run_cmd(op, data, cnt, bit'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_counting();
    test_shift();
    test_zero_step();
    test_ignore_busy();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_bank_ctrl.md
# jk_bank_ctrl

Command-driven sequencer for a bank of WIDTH JK flip-flops. Accepts one command at a time over a valid/ready handshake and, each cycle, drives per-bit J/K to load, clear, set, toggle, count up or down, or shift the bank. It is the control layer between system logic and the JK storage cells. Multi-step commands run for a programmed number of clock cycles, then signal completion with a one-cycle `done` pulse.

## Interface
- WIDTH, 4, number of JK cells in the bank (≥2)
- CNT_W, 8, width of step-count field

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept; high only in IDLE
- cmd_op  in  3  opcode
- cmd_data  in  WIDTH  operand (load value / toggle mask / serial-in in bit 0)
- cmd_count  in  CNT_W  step count for multi-step ops
- q  out  WIDTH  bank state
- busy  out  1  high in RUN or DONE
- done  out  1  one-cycle pulse at command completion

## Operation
- Opcodes: 0 NOP, 1 LOAD, 2 CLEAR, 3 SET, 4 TOGGLE, 5 CNT_UP, 6 CNT_DN, 7 SHL.
- Per-bit J/K drive in RUN:
  - LOAD: j=data, k=~data.
  - CLEAR: j=0, k=1.
  - SET: j=1, k=0.
  - TOGGLE: j=k=data.
  - CNT_UP: j=k=t[i], t[0]=1, t[i]=&q[i-1:0].
  - CNT_DN: same with ~q.
  - SHL: next[0]=data[0], next[i]=q[i-1]; j=next, k=~next.
- Idle/DONE drive: j=k=0 (hold).
- Handshake: a command is accepted on an edge where cmd_valid & cmd_ready. cmd_op/data/count are captured into internal registers on accept; inputs are don't-care afterwards.
- Step count:
  - Ops 1–4 always run 1 step.
  - Ops 5–7 run cmd_count steps.
  - NOP, or cmd_count=0 on ops 5–7, runs 0 steps.
- FSM:
  - IDLE: accept → RUN with remaining=steps, or → DONE directly if steps=0.
  - RUN: drive J/K, remaining−1; on remaining==1 → DONE.
  - DONE: done=1 → IDLE.
- Arithmetic: counting wraps modulo 2^WIDTH (1111+1=0000, 0000−1=1111). Remaining counter is CNT_W bits and never underflows.
- cmd_valid while busy: ignored (cmd_ready=0); the command is not queued.
- Reset: q=0, state IDLE, cmd_ready=1, busy=0, done=0, captured regs=0. Reset takes priority in any state, including mid-RUN; the in-flight command is abandoned with no done pulse.

## Timing
- Cycle 0: accept. Cycles 1..n: RUN, with q updated at the end of each RUN cycle. Cycle n+1: DONE (done=1, q final). Cycle n+2: IDLE, cmd_ready=1.
- Single-step op: done in cycle 2, next accept earliest in cycle 3 (3-cycle throughput).
- Zero-step op: done in cycle 1, q unchanged.
- q is registered and changes only on clock edges ending RUN cycles.
- cmd_ready, busy and done are decoded from the state register only, with no combinational path from inputs.

## Structure
- Shared package/include `jk_ctrl_pkg`:
  - opcode localparams OP_NOP..OP_SHL
  - FSM state encoding S_IDLE, S_RUN, S_DONE
- Sub-module `jk_cell`: one JK flip-flop with clock, synchronous active-high reset to 0, and j/k → q semantics 00 hold, 01 clear, 10 set, 11 toggle. It is instantiated WIDTH times via generate.
- Top level holds: FSM, captured command registers, remaining counter, J/K decode.

## Test plan
- Reset then idle: assert reset 2 cycles → q=0000, cmd_ready=1, busy=0, done=0. After 5 idle cycles q stays 0000.
- Single-step ops:
  - LOAD 1010 → q=1010 at end of cycle 1, done in cycle 2.
  - TOGGLE 0110 → q=1100.
  - SET → q=1111.
  - CLEAR → q=0000.
  - Check cmd_ready=0 throughout cycles 1–2.
- Counting with wrap:
  - From q=1101, CNT_UP count=5 → q sequence 1110, 1111, 0000, 0001, 0010. done in cycle 6.
  - Then CNT_DN count=3 → 0001, 0000, 1111.
- Shift: from 0000, SHL data[0]=1 count=3 → 0001, 0011, 0111, done after 3 RUN cycles.
- Boundaries:
  - CNT_UP with count=0 → done in cycle 1, q unchanged.
  - NOP → same behaviour as count=0.
  - cmd_valid held high with a different command during RUN → ignored; only accepted once back in IDLE.
- Reset mid-operation: start CNT_UP count=10 from 0000 and assert reset in RUN cycle 4 → next cycle q=0000, IDLE, cmd_ready=1, and no done pulse is ever seen for that command.
